// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours.
// Includes the fetch FSM encoding, the canonical NOP and the PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, presents instr/pc to the decoder,
// and applies branch redirects by discarding or flushing wrong-path fetches.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned                 ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = {ADDRESS_WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     mem_req_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [ADDRESS_WIDTH-1:0] mem_rsp_data,
    output logic                     instr_valid,
    output logic [ADDRESS_WIDTH-1:0] instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] pc
);

    localparam logic [ADDRESS_WIDTH-1:0] STEP_C = ADDRESS_WIDTH'(PC_STEP);
    localparam logic [ADDRESS_WIDTH-1:0] NOP_C  = ADDRESS_WIDTH'(NOP_INSTR);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_C = {ADDRESS_WIDTH{1'b0}};

    fetch_state_t               state_r;
    fetch_state_t               state_nxt_s;
    logic [ADDRESS_WIDTH-1:0]   pc_r;
    logic [ADDRESS_WIDTH-1:0]   pc_nxt_s;
    logic [ADDRESS_WIDTH-1:0]   pc_inflight_r;
    logic                       drop_r;
    logic                       drop_nxt_s;
    logic                       drop_eff_s;
    logic                       accept_s;
    logic                       load_instr_s;
    logic                       clear_valid_s;
    logic                       mem_req_valid_r;
    logic [ADDRESS_WIDTH-1:0]   mem_req_addr_r;
    logic                       instr_valid_r;
    logic [ADDRESS_WIDTH-1:0]   instr_r;
    logic [ADDRESS_WIDTH-1:0]   instr_pc_r;
    logic [ADDRESS_WIDTH-1:0]   target_aligned_s;

    assign target_aligned_s = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};

    // Next-state, drop tracking and pc selection
    always_comb begin
        state_nxt_s   = state_r;
        drop_nxt_s    = drop_r;
        accept_s      = 1'b0;
        load_instr_s  = 1'b0;
        clear_valid_s = 1'b0;
        // A redirect arriving with the response still makes that response wrong-path.
        drop_eff_s    = drop_r | redirect;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                drop_nxt_s = drop_eff_s;
                if (mem_req_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    drop_nxt_s = 1'b0;
                    if (drop_eff_s) begin
                        state_nxt_s = en ? REQ : IDLE;
                    end else begin
                        load_instr_s = 1'b1;
                        state_nxt_s  = HOLD;
                    end
                end else begin
                    drop_nxt_s  = drop_eff_s;
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (instr_ready || redirect) begin
                    clear_valid_s = 1'b1;
                    state_nxt_s   = en ? REQ : IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                drop_nxt_s  = 1'b0;
            end
        endcase

        if (redirect) begin
            pc_nxt_s = target_aligned_s;
        end else if (load_instr_s) begin
            pc_nxt_s = pc_r + STEP_C;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // FSM, pc and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            pc_inflight_r <= RESET_PC;
            drop_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            drop_r  <= drop_nxt_s;
            if (accept_s) begin
                pc_inflight_r <= mem_req_addr_r;
            end
        end
    end

    // Memory request port; address is captured on entry to REQ and frozen until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= RESET_PC;
        end else begin
            mem_req_valid_r <= (state_nxt_s == REQ);
            if ((state_nxt_s == REQ) && (state_r != REQ)) begin
                mem_req_addr_r <= pc_nxt_s;
            end
        end
    end

    // Decoder-facing instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_r <= 1'b0;
            instr_r       <= NOP_C;
            instr_pc_r    <= ZERO_C;
        end else begin
            if (load_instr_s) begin
                instr_valid_r <= 1'b1;
                instr_r       <= mem_rsp_data;
                instr_pc_r    <= pc_inflight_r;
            end else if (clear_valid_s) begin
                instr_valid_r <= 1'b0;
            end
        end
    end

    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign instr_valid   = instr_valid_r;
    assign instr         = instr_r;
    assign instr_pc      = instr_pc_r;
    assign pc            = pc_r;

endmodule
